// File: rtl/rv32_memory_stage_ooo_resp.sv
// rtl/rv32_memory_stage_ooo_resp.sv - in-order memory stage with variable-latency load responses
//
// Purpose: sits between execute and writeback. Instructions enter an in-order
// buffer of DEPTH entries. Loads wait there for their in-order response, and
// everything retires to writeback in acceptance order.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i / stall_o            execute handshake (accept = valid_i && !stall_o)
//   reg_write_i .. fpu_result_i  instruction payload from execute
//   mem_req_o / mem_gnt_i        data memory request channel
//   mem_we_o, mem_addr_o, mem_wdata_o
//                                byte enables, word address, lane-replicated data
//   mem_rvalid_i, mem_rdata_i    in-order load response channel
//   valid_o .. misaligned_o      registered writeback outputs, one retire per cycle
//
// Optional feature: define RV32_MEM_BUS_ERR_EN to add mem_err_i and load_fault_o.
module rv32_memory_stage_ooo_resp #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        stall_o,
  input  logic        reg_write_i,
  input  logic        fp_reg_write_i,
  input  logic        memory_write_i,
  input  logic        memory_read_i,
  input  logic [2:0]  result_source_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] write_data_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_next_i,
  input  logic [31:0] fpu_result_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        valid_o,
  output logic        reg_write_o,
  output logic        fp_reg_write_o,
  output logic [2:0]  result_source_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] read_data_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_next_o,
  output logic [31:0] fpu_result_o,
  output logic        misaligned_o
`ifdef RV32_MEM_BUS_ERR_EN
  ,
  input  logic        mem_err_i,
  output logic        load_fault_o
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] e_done, e_mis, e_rw, e_frw, e_err;
  logic [2:0]       e_src   [DEPTH];
  logic [31:0]      e_alu   [DEPTH];
  logic [31:0]      e_rdata [DEPTH];
  logic [31:0]      e_instr [DEPTH];
  logic [31:0]      e_pc    [DEPTH];
  logic [31:0]      e_fpu   [DEPTH];

  logic [PTR_W-1:0] head, tail, ld_idx, cand;
  logic [PTR_W:0]   count;
  logic [2:0]       f3;
  logic             is_mem, mis, full, accept, retire, ld_found, rsp_take, rsp_err;

`ifdef RV32_MEM_BUS_ERR_EN
  assign rsp_err = mem_err_i;
`else
  assign rsp_err = 1'b0;
`endif

  function automatic logic [31:0] fmt_load(input logic [2:0] fn, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (fn)
      3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
      3'b100:  fmt_load = {24'h0, sh[7:0]};
      3'b101:  fmt_load = {16'h0, sh[15:0]};
      default: fmt_load = word;
    endcase
  endfunction

  always_comb begin
    f3     = instr_i[14:12];
    is_mem = memory_read_i | memory_write_i;
    case (f3)
      3'b010:         mis = alu_result_i[1:0] != 2'b00;
      3'b001, 3'b101: mis = alu_result_i[0];
      default:        mis = 1'b0;
    endcase
    mis       = mis & is_mem;
    full      = count == FULL_CNT;
    mem_req_o = valid_i && is_mem && !mis && !full;
    stall_o   = valid_i && (full || (is_mem && !mis && !mem_gnt_i));
    accept    = valid_i && !stall_o;

    mem_addr_o  = {alu_result_i[31:2], 2'b00};
    mem_we_o    = 4'b0000;
    mem_wdata_o = write_data_i;
    if (memory_write_i) begin
      case (f3[1:0])
        2'b00: begin
          mem_we_o    = 4'b0001 << alu_result_i[1:0];
          mem_wdata_o = {4{write_data_i[7:0]}};
        end
        2'b01: begin
          mem_we_o    = 4'b0011 << alu_result_i[1:0];
          mem_wdata_o = {2{write_data_i[15:0]}};
        end
        default: mem_we_o = 4'b1111;
      endcase
    end
  end

  // Only loads are ever pending and they complete in order, so the oldest
  // pending load is simply the first incomplete entry walking from head.
  always_comb begin
    ld_found = 1'b0;
    ld_idx   = '0;
    cand     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand = head + PTR_W'(i);
      if (!ld_found && ((PTR_W+1)'(i) < count) && !e_done[cand]) begin
        ld_found = 1'b1;
        ld_idx   = cand;
      end
    end
  end

  assign rsp_take = mem_rvalid_i && ld_found;
  assign retire   = (count != '0) && e_done[head];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      e_done          <= '0;
      valid_o         <= 1'b0;
      reg_write_o     <= 1'b0;
      fp_reg_write_o  <= 1'b0;
      misaligned_o    <= 1'b0;
      result_source_o <= '0;
      alu_result_o    <= '0;
      read_data_o     <= '0;
      instr_o         <= '0;
      pc_next_o       <= '0;
      fpu_result_o    <= '0;
`ifdef RV32_MEM_BUS_ERR_EN
      load_fault_o    <= 1'b0;
`endif
    end else begin
      // Accept and response never target the same slot: tail is free, ld_idx is occupied.
      if (accept) begin
        e_done[tail]  <= !(memory_read_i && !mis);
        e_mis[tail]   <= mis;
        e_rw[tail]    <= reg_write_i & ~mis;
        e_frw[tail]   <= fp_reg_write_i & ~mis;
        e_err[tail]   <= 1'b0;
        e_src[tail]   <= result_source_i;
        e_alu[tail]   <= alu_result_i;
        e_rdata[tail] <= '0;
        e_instr[tail] <= instr_i;
        e_pc[tail]    <= pc_next_i;
        e_fpu[tail]   <= fpu_result_i;
        tail          <= tail + 1'b1;
      end
      if (rsp_take) begin
        e_done[ld_idx]  <= 1'b1;
        e_err[ld_idx]   <= rsp_err;
        e_rdata[ld_idx] <= fmt_load(e_instr[ld_idx][14:12], e_alu[ld_idx][1:0], mem_rdata_i);
      end

      valid_o        <= retire;
      reg_write_o    <= retire && e_rw[head] && !e_err[head];
      fp_reg_write_o <= retire && e_frw[head] && !e_err[head];
      misaligned_o   <= retire && e_mis[head];
`ifdef RV32_MEM_BUS_ERR_EN
      load_fault_o   <= retire && e_err[head];
`endif
      if (retire) begin
        result_source_o <= e_src[head];
        alu_result_o    <= e_alu[head];
        read_data_o     <= e_err[head] ? 32'h0 : e_rdata[head];
        instr_o         <= e_instr[head];
        pc_next_o       <= e_pc[head];
        fpu_result_o    <= e_fpu[head];
        head            <= head + 1'b1;
      end

      case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_memory_stage_ooo_resp.sv
// tb/tb_rv32_memory_stage_ooo_resp.sv - scoreboard bench for rv32_memory_stage_ooo_resp
module tb_rv32_memory_stage_ooo_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_o, reg_write_i, fp_reg_write_i, memory_write_i, memory_read_i;
  logic [2:0]  result_source_i;
  logic [31:0] alu_result_i, write_data_i, instr_i, pc_next_i, fpu_result_i;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        valid_o, reg_write_o, fp_reg_write_o, misaligned_o;
  logic [2:0]  result_source_o;
  logic [31:0] alu_result_o, read_data_o, instr_o, pc_next_o, fpu_result_o;
`ifdef RV32_MEM_BUS_ERR_EN
  logic        mem_err_i = 1'b0;
  logic        load_fault_o;
`endif

  always #5 clk = ~clk;

  rv32_memory_stage_ooo_resp #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .stall_o(stall_o),
    .reg_write_i(reg_write_i), .fp_reg_write_i(fp_reg_write_i),
    .memory_write_i(memory_write_i), .memory_read_i(memory_read_i),
    .result_source_i(result_source_i), .alu_result_i(alu_result_i),
    .write_data_i(write_data_i), .instr_i(instr_i), .pc_next_i(pc_next_i),
    .fpu_result_i(fpu_result_i), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .valid_o(valid_o),
    .reg_write_o(reg_write_o), .fp_reg_write_o(fp_reg_write_o),
    .result_source_o(result_source_o), .alu_result_o(alu_result_o),
    .read_data_o(read_data_o), .instr_o(instr_o), .pc_next_o(pc_next_o),
    .fpu_result_o(fpu_result_o), .misaligned_o(misaligned_o)
`ifdef RV32_MEM_BUS_ERR_EN
    , .mem_err_i(mem_err_i), .load_fault_o(load_fault_o)
`endif
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        mis;
    logic        rw;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t got;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] alu, input logic [31:0] rd, input logic crd,
                      input logic mis, input logic rw, input int c);
    exp_t e;
    e.alu = alu; e.rdata = rd; e.chk_rdata = crd; e.mis = mis; e.rw = rw; e.cyc = c;
    sbq.push_back(e);
  endtask

  // Monitor: every retire is matched against the oldest expected record.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid_o", {31'h0, valid_o}, 32'h0);
      end else begin
        got = sbq.pop_front();
        chk("ret_alu", alu_result_o, got.alu);
        chk("ret_misaligned", {31'h0, misaligned_o}, {31'h0, got.mis});
        chk("ret_reg_write", {31'h0, reg_write_o}, {31'h0, got.rw});
        if (got.chk_rdata) chk("ret_read_data", read_data_o, got.rdata);
        if (got.cyc >= 0) chk("ret_cycle", cyc, got.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] fn,
                       input logic [31:0] alu, input logic [31:0] wd, input logic rw);
    valid_i = 1'b1; memory_read_i = rd; memory_write_i = wr;
    instr_i = {17'h0, fn, 12'h0}; alu_result_i = alu; write_data_i = wd; reg_write_i = rw;
  endtask

  task automatic idle();
    valid_i = 1'b0; memory_read_i = 1'b0; memory_write_i = 1'b0; reg_write_i = 1'b0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_valid_o"}, {31'h0, valid_o}, 32'h0);
    chk({tag, "_reg_write_o"}, {31'h0, reg_write_o}, 32'h0);
    chk({tag, "_misaligned_o"}, {31'h0, misaligned_o}, 32'h0);
    chk({tag, "_alu_result_o"}, alu_result_o, 32'h0);
    chk({tag, "_read_data_o"}, read_data_o, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   accept_k;
    logic added;
    rst = 1'b1; idle();
    fp_reg_write_i = 1'b0; result_source_i = 3'd0; pc_next_i = 32'h0; fpu_result_i = 32'h0;
    instr_i = 32'h0; alu_result_i = 32'h0; write_data_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (3) tick();
    chk_outs_zero("reset");
    chk("reset_stall_o", {31'h0, stall_o}, 32'h0);
    rst = 1'b0;
    tick();

    // ADD into empty buffer: valid_o exactly two cycles later
    issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b1);
    #1 chk("add_stall_o", {31'h0, stall_o}, 32'h0);
    push(32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, cyc + 2);
    tick(); idle();
    repeat (4) tick();

    // LB at 0x103, response three cycles later
    mem_gnt_i = 1'b1;
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1);
    #1;
    chk("lb_req", {31'h0, mem_req_o}, 32'h1);
    chk("lb_addr", mem_addr_o, 32'h100);
    chk("lb_we", {28'h0, mem_we_o}, 32'h0);
    chk("lb_stall", {31'h0, stall_o}, 32'h0);
    push(32'h103, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1, cyc + 5);
    tick(); idle();
    tick(); tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_FF00;
    tick();
    mem_rvalid_i = 1'b0;
    repeat (4) tick();

    // SH at 0x102 with grant withheld for two cycles
    mem_gnt_i = 1'b0;
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'hABCD_1234, 1'b0);
    #1;
    chk("sh_stall_c0", {31'h0, stall_o}, 32'h1);
    chk("sh_req", {31'h0, mem_req_o}, 32'h1);
    chk("sh_we", {28'h0, mem_we_o}, 32'hC);
    chk("sh_wdata", mem_wdata_o, 32'h1234_1234);
    chk("sh_addr", mem_addr_o, 32'h100);
    tick();
    chk("sh_stall_c1", {31'h0, stall_o}, 32'h1);
    tick();
    mem_gnt_i = 1'b1;
    #1 chk("sh_stall_c2", {31'h0, stall_o}, 32'h0);
    push(32'h102, 32'h0, 1'b0, 1'b0, 1'b0, -1);
    tick(); idle();
    repeat (3) tick();

    // Misaligned LW: no request, retires flagged with reg_write cleared
    mem_gnt_i = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1);
    #1;
    chk("mis_req", {31'h0, mem_req_o}, 32'h0);
    chk("mis_stall", {31'h0, stall_o}, 32'h0);
    push(32'h101, 32'h0, 1'b0, 1'b1, 1'b0, -1);
    tick(); idle();
    repeat (3) tick();

    // Fill all four entries with loads, then an ADD must stall
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, 3'b010, 32'h200 + 32'(4 * i), 32'h0, 1'b1);
      #1 chk("fill_stall", {31'h0, stall_o}, 32'h0);
      push(32'h200 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 1'b1, 1'b0, 1'b1, -1);
      tick();
    end
    issue(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 1'b1);
    #1 chk("full_stall_c0", {31'h0, stall_o}, 32'h1);
    tick();
    chk("full_stall_c1", {31'h0, stall_o}, 32'h1);
    added = 1'b0;
    accept_k = -1;
    for (int k = 0; k < 12; k++) begin
      mem_rvalid_i = (k < 4);
      mem_rdata_i  = 32'h1111_1111 * 32'(k + 1);
      #1;
      if (!added && !stall_o) begin
        push(32'h55, 32'h0, 1'b0, 1'b0, 1'b1, -1);
        added = 1'b1;
        accept_k = k;
      end
      tick();
      if (added) idle();
    end
    mem_rvalid_i = 1'b0;
    chk("add_after_full_accept_k", accept_k, 32'd2);
    repeat (3) tick();

    // Reset with two loads pending, then a stray response
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1);
    tick();
    issue(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 1'b1);
    tick(); idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs_zero("rst2");
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stray_valid_o", {31'h0, valid_o}, 32'h0);
      tick();
    end
    chk("stray_read_data_o", read_data_o, 32'h0);

    chk("scoreboard_empty", sbq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
